// File: rtl/regbank_dump_sequencer.sv
// rtl/regbank_dump_sequencer.sv - stalls the pipeline and streams the register bank out as bytes
module regbank_dump_sequencer #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dumpReq,
    input  logic [ADDR_W-1:0] pipeAddr1,
    input  logic [ADDR_W-1:0] pipeWriteAddr,
    input  logic [DATA_W-1:0] pipeWriteData,
    input  logic              pipeRegWrite,
    output logic [ADDR_W-1:0] bankAddr1,
    output logic [ADDR_W-1:0] bankWriteAddr,
    output logic [DATA_W-1:0] bankWriteData,
    output logic              bankRegWrite,
    input  logic [DATA_W-1:0] bankReg1,
    output logic              stall,
    output logic              dumpBusy,
    output logic              dumpDone,
    output logic [7:0]        txData,
    output logic              txValid,
    input  logic              txReady
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_READ  = 3'd2,
        ST_LATCH = 3'd3,
        ST_SEND  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] reg_idx_q,  reg_idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0] shreg_q,    shreg_d;

    // Next-state logic: walk every register, four bytes each, LSB first
    always_comb begin
        state_d    = state_q;
        reg_idx_d  = reg_idx_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (dumpReq) begin
                    state_d    = ST_DRAIN;
                    reg_idx_d  = '0;
                    byte_cnt_d = '0;
                end
            end
            ST_DRAIN: state_d = ST_READ;
            ST_READ:  state_d = ST_LATCH;
            ST_LATCH: begin
                // Bank data for reg_idx is valid one cycle after the address was presented
                shreg_d    = bankReg1;
                byte_cnt_d = '0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (txReady) begin
                    shreg_d    = shreg_q >> 8;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (reg_idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            reg_idx_d = reg_idx_q + 1'b1;
                            state_d   = ST_READ;
                        end
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any dump in progress
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            reg_idx_q  <= '0;
            byte_cnt_q <= '0;
            shreg_q    <= '0;
        end else begin
            state_q    <= state_d;
            reg_idx_q  <= reg_idx_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
        end
    end

    // Moore-decoded control; the bank port is borrowed only during READ
    always_comb begin
        stall        = (state_q != ST_IDLE);
        dumpBusy     = (state_q != ST_IDLE);
        dumpDone     = (state_q == ST_DONE);
        txValid      = (state_q == ST_SEND);
        txData       = shreg_q[7:0];
        bankAddr1    = (state_q == ST_READ) ? reg_idx_q : pipeAddr1;
        // Writeback may still commit while draining; a frozen WB must not rewrite afterwards
        bankRegWrite = ((state_q == ST_IDLE) || (state_q == ST_DRAIN)) ? pipeRegWrite : 1'b0;
        bankWriteAddr = pipeWriteAddr;
        bankWriteData = pipeWriteData;
    end

endmodule

// File: tb/tb_regbank_dump_sequencer.sv
// tb/tb_regbank_dump_sequencer.sv - scoreboard bench for regbank_dump_sequencer
module tb_regbank_dump_sequencer;

    localparam int N = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        dumpReq;
    logic [4:0]  pipeAddr1;
    logic [4:0]  pipeWriteAddr;
    logic [31:0] pipeWriteData;
    logic        pipeRegWrite;
    logic [4:0]  bankAddr1;
    logic [4:0]  bankWriteAddr;
    logic [31:0] bankWriteData;
    logic        bankRegWrite;
    logic [31:0] bankReg1;
    logic        stall;
    logic        dumpBusy;
    logic        dumpDone;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;

    always #5 clock = ~clock;

    regbank_dump_sequencer #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clock(clock), .reset(reset), .dumpReq(dumpReq),
        .pipeAddr1(pipeAddr1), .pipeWriteAddr(pipeWriteAddr),
        .pipeWriteData(pipeWriteData), .pipeRegWrite(pipeRegWrite),
        .bankAddr1(bankAddr1), .bankWriteAddr(bankWriteAddr),
        .bankWriteData(bankWriteData), .bankRegWrite(bankRegWrite),
        .bankReg1(bankReg1), .stall(stall), .dumpBusy(dumpBusy),
        .dumpDone(dumpDone), .txData(txData), .txValid(txValid),
        .txReady(txReady)
    );

    // Register bank: synchronous read on rising edge, write on falling edge
    logic [31:0] bank_mem [N];
    always @(negedge clock) if (bankRegWrite) bank_mem[bankWriteAddr] <= bankWriteData;
    always @(posedge clock) bankReg1 <= bank_mem[bankAddr1];

    logic [31:0] ref_mem [N];
    logic [7:0]  exp_q [$];
    int total = 0;
    int bad = 0;
    int popped = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: compare each accepted byte against the scoreboard, check hold stability
    initial begin
        logic       prev_hold;
        logic [7:0] prev_data;
        prev_hold = 1'b0;
        prev_data = 8'h00;
        forever begin
            @(negedge clock);
            if (dumpDone) done_cnt++;
            if (txValid && prev_hold) chk("tx_stable", txData, prev_data);
            if (txValid && txReady) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_extra: got %h expected no byte", txData);
                end else begin
                    chk("tx_byte", txData, exp_q.pop_front());
                end
                popped++;
            end
            prev_hold = txValid && !txReady;
            prev_data = txData;
        end
    end

    task automatic preload(input bit pattern);
        for (int i = 0; i < N; i++) begin
            ref_mem[i]    = pattern ? 32'h11111111 * (i + 1) : $urandom;
            pipeRegWrite  = 1'b1;
            pipeWriteAddr = 5'(i);
            pipeWriteData = ref_mem[i];
            step();
        end
        pipeRegWrite = 1'b0;
    endtask

    // mode 0: txReady held high; mode 1: txReady high one cycle in three
    task automatic run_dump(input int mode, input bit drain_wr, input bit extra_req, input int abort_at);
        int cyc;
        int d0;
        if (drain_wr) ref_mem[5] = 32'hCAFEF00D;
        for (int i = 0; i < N; i++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(ref_mem[i][8*b +: 8]);
        d0 = done_cnt;
        popped = 0;
        dumpReq = 1'b1;
        if (drain_wr) begin
            pipeRegWrite  = 1'b1;
            pipeWriteAddr = 5'd5;
            pipeWriteData = 32'hCAFEF00D;
        end
        txReady = (mode == 0);
        step();
        dumpReq = 1'b0;
        cyc = 1;
        chk("stall_after_req", stall, 1);
        while (!dumpDone && cyc < 2000) begin
            if (drain_wr && cyc >= 2) pipeWriteData = 32'h0BADBAD0;
            if (mode == 1) txReady = (cyc % 3 == 0);
            if (extra_req) dumpReq = (cyc == 50);
            if (abort_at > 0 && popped >= abort_at) break;
            step();
            cyc++;
        end
        if (abort_at > 0) begin
            chk("pre_abort_valid", txValid, 1);
            #2 reset = 1'b0;
            #1;
            chk("abort_txvalid", txValid, 0);
            chk("abort_stall", stall, 0);
            chk("abort_busy", dumpBusy, 0);
            exp_q.delete();
            step();
            reset = 1'b1;
            txReady = 1'b0;
            return;
        end
        chk("dump_finished", dumpDone, 1);
        if (mode == 0) chk("dump_cycles", cyc, 194);
        step();
        pipeRegWrite = 1'b0;
        txReady = 1'b0;
        chk("stall_after_done", stall, 0);
        chk("busy_after_done", dumpBusy, 0);
        chk("done_pulses", done_cnt - d0, 1);
        chk("bytes_sent", popped, 128);
        chk("bytes_left", exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b0; dumpReq = 1'b0; pipeAddr1 = 5'd0; pipeWriteAddr = 5'd0;
        pipeWriteData = 32'd0; pipeRegWrite = 1'b0; txReady = 1'b0;
        step();
        step();
        chk("rst_stall", stall, 0);
        chk("rst_busy", dumpBusy, 0);
        chk("rst_done", dumpDone, 0);
        chk("rst_txvalid", txValid, 0);
        chk("rst_txdata", txData, 0);
        reset = 1'b1;
        pipeAddr1 = 5'd9;
        #1 chk("rst_addr_pass", bankAddr1, 9);

        // Idle pass-through
        step();
        pipeAddr1 = 5'd7; pipeRegWrite = 1'b1; pipeWriteAddr = 5'd3; pipeWriteData = 32'hDEADBEEF;
        #1;
        chk("idle_addr1", bankAddr1, 7);
        chk("idle_regwrite", bankRegWrite, 1);
        chk("idle_waddr", bankWriteAddr, 3);
        chk("idle_wdata", bankWriteData, 32'hDEADBEEF);
        chk("idle_stall", stall, 0);
        step();
        pipeRegWrite = 1'b0; pipeAddr1 = 5'd3;
        step();
        chk("idle_readback", bankReg1, 32'hDEADBEEF);

        // Full dump with the reference pattern
        preload(1'b1);
        run_dump(0, 1'b0, 1'b0, 0);

        // Drain write then blocked writes
        preload(1'b0);
        run_dump(0, 1'b1, 1'b0, 0);
        pipeAddr1 = 5'd5;
        step();
        step();
        chk("reg5_after_dump", bankReg1, 32'hCAFEF00D);

        // Backpressure
        preload(1'b0);
        run_dump(1, 1'b0, 1'b0, 0);

        // Reset mid-dump during register 10, then a clean restart
        preload(1'b0);
        run_dump(0, 1'b0, 1'b0, 42);
        step();
        run_dump(0, 1'b0, 1'b0, 0);

        // Request while busy is ignored
        run_dump(0, 1'b0, 1'b1, 0);
        step();
        step();
        chk("no_second_dump", dumpBusy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
